// File: rtl/axis_window_crop_pkg.sv
// Shared constants for the video stream stages: default pixel/geometry widths
// and the crop/scaler frame-tracking state encoding.
package axis_window_crop_pkg;

    localparam int C_PIXEL_WIDTH_DEF = 8;
    localparam int C_IMG_WBITS_DEF   = 12;
    localparam int C_IMG_HBITS_DEF   = 12;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

endpackage

// File: rtl/axis_skid_fifo2.sv
// Two-entry registered skid buffer with flush; 'room' is a registered
// "at most one entry occupied" flag usable directly as an upstream ready.
module axis_skid_fifo2
    import axis_window_crop_pkg::*;
#(
    parameter int DATA_W = C_PIXEL_WIDTH_DEF + 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              m_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              room
);

    logic [1:0]        cnt_p1;
    logic [1:0]        cnt_nxt;
    logic [DATA_W-1:0] head_p1;
    logic [DATA_W-1:0] tail_p1;
    logic              pop;

    assign m_valid = (cnt_p1 != 2'd0);
    assign m_data  = head_p1;
    assign pop     = m_valid && m_ready;

    always_comb begin
        cnt_nxt = cnt_p1;
        if (flush)
            cnt_nxt = 2'd0;
        else if (push && !pop)
            cnt_nxt = cnt_p1 + 2'd1;
        else if (pop && !push)
            cnt_nxt = cnt_p1 - 2'd1;
    end

    // ---- storage stage: head is the presented beat, tail the skid slot ----
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_p1  <= 2'd0;
            room    <= 1'b0;
            head_p1 <= '0;
        end else begin
            cnt_p1 <= cnt_nxt;
            room   <= (cnt_nxt <= 2'd1);
            if (pop && cnt_p1 == 2'd2)
                head_p1 <= tail_p1;
            else if (push && (cnt_p1 == 2'd0 || (cnt_p1 == 2'd1 && pop)))
                head_p1 <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push && ((cnt_p1 == 2'd1 && !pop) || (cnt_p1 == 2'd2 && pop)))
            tail_p1 <= push_data;
    end

endmodule

// File: rtl/axis_window_crop.sv
// AXI4-Stream crop: keeps a latched (left, top, width, height) window of each
// frame and regenerates tuser/tlast so the downstream sees the window as a frame.
module axis_window_crop
    import axis_window_crop_pkg::*;
#(
    parameter int C_PIXEL_WIDTH = C_PIXEL_WIDTH_DEF,
    parameter int C_IMG_WBITS   = C_IMG_WBITS_DEF,
    parameter int C_IMG_HBITS   = C_IMG_HBITS_DEF
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     fsync,
    input  logic [C_IMG_WBITS-1:0]   win_left,
    input  logic [C_IMG_HBITS-1:0]   win_top,
    input  logic [C_IMG_WBITS-1:0]   win_width,
    input  logic [C_IMG_HBITS-1:0]   win_height,
    input  logic                     s_axis_tvalid,
    input  logic [C_PIXEL_WIDTH-1:0] s_axis_tdata,
    input  logic                     s_axis_tuser,
    input  logic                     s_axis_tlast,
    output logic                     s_axis_tready,
    output logic                     m_axis_tvalid,
    output logic [C_PIXEL_WIDTH-1:0] m_axis_tdata,
    output logic                     m_axis_tuser,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready
);

    localparam int WB     = C_IMG_WBITS;
    localparam int HB     = C_IMG_HBITS;
    localparam int BEAT_W = C_PIXEL_WIDTH + 2;

    logic [1:0]    state;
    logic [WB-1:0] lat_left, lat_width, col;
    logic [HB-1:0] lat_top, lat_height, row;

    function automatic logic [WB-1:0] sat_inc_col(input logic [WB-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [HB-1:0] sat_inc_row(input logic [HB-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // ---- stage p0: classify the beat on the input handshake ----
    logic               accept, active, keep, room;
    logic [WB-1:0]      beat_col;
    logic [HB-1:0]      beat_row;
    logic signed [WB:0] dcol, wlast;
    logic signed [HB:0] drow;
    logic               o_user, o_last;
    logic [BEAT_W-1:0]  push_data_p0;
    logic [BEAT_W-1:0]  out_data_p1;

    assign s_axis_tready = room && (state != ST_IDLE);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign active        = accept && !fsync &&
                           ((state == ST_RUN) || (state == ST_SYNC && s_axis_tuser));

    // A tuser beat is always (0,0), whether it arms the frame or resyncs it.
    assign beat_col = s_axis_tuser ? '0 : col;
    assign beat_row = s_axis_tuser ? '0 : row;

    // One bit wider and signed so left+width never wraps.
    assign dcol  = $signed({1'b0, beat_col}) - $signed({1'b0, lat_left});
    assign drow  = $signed({1'b0, beat_row}) - $signed({1'b0, lat_top});
    assign wlast = $signed({1'b0, lat_width}) - $signed({{WB{1'b0}}, 1'b1});
    assign keep  = !dcol[WB] && (dcol < $signed({1'b0, lat_width})) &&
                   !drow[HB] && (drow < $signed({1'b0, lat_height}));

    assign o_user       = (beat_col == lat_left) && (beat_row == lat_top);
    assign o_last       = (dcol == wlast) || s_axis_tlast;
    assign push_data_p0 = {s_axis_tdata, o_user, o_last};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            col        <= '0;
            row        <= '0;
            lat_left   <= '0;
            lat_top    <= '0;
            lat_width  <= '0;
            lat_height <= '0;
        end else if (fsync) begin
            state      <= ST_SYNC;
            col        <= '0;
            row        <= '0;
            lat_left   <= win_left;
            lat_top    <= win_top;
            lat_width  <= win_width;
            lat_height <= win_height;
        end else if (active) begin
            state <= ST_RUN;
            if (s_axis_tlast) begin
                col <= '0;
                row <= sat_inc_row(beat_row);
            end else begin
                col <= sat_inc_col(beat_col);
                row <= beat_row;
            end
        end
    end

    // ---- stage p1: skid buffer drives the master port ----
    axis_skid_fifo2 #(
        .DATA_W(BEAT_W)
    ) u_skid (
        .clk      (clk),
        .resetn   (resetn),
        .flush    (fsync),
        .push     (active && keep),
        .push_data(push_data_p0),
        .m_ready  (m_axis_tready),
        .m_valid  (m_axis_tvalid),
        .m_data   (out_data_p1),
        .room     (room)
    );

    assign m_axis_tdata = out_data_p1[BEAT_W-1:2];
    assign m_axis_tuser = out_data_p1[1];
    assign m_axis_tlast = out_data_p1[0];

endmodule

// File: tb/tb_axis_window_crop.sv
// Scoreboard bench for axis_window_crop: directed frames push hand-computed
// expected beats; a negedge monitor pops and compares every output transfer.
module tb_axis_window_crop;

    localparam int PW = 8;
    localparam int WB = 12;
    localparam int HB = 12;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          fsync = 1'b0;
    logic [WB-1:0] win_left = '0, win_width = '0;
    logic [HB-1:0] win_top = '0, win_height = '0;
    logic          s_tvalid = 1'b0;
    logic [PW-1:0] s_tdata = '0;
    logic          s_tuser = 1'b0, s_tlast = 1'b0;
    logic          s_tready;
    logic          m_tvalid;
    logic [PW-1:0] m_tdata;
    logic          m_tuser, m_tlast;
    logic          m_tready = 1'b1;
    int            rmode = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       u;
        logic       l;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0, n_pass = 0;
    int    cyc = 0;
    int    mark_cyc = -1, first_out_cyc = -2;
    int    stall_cnt = 0, out_cnt = 0;

    always #5 clk = ~clk;

    axis_window_crop #(
        .C_PIXEL_WIDTH(PW), .C_IMG_WBITS(WB), .C_IMG_HBITS(HB)
    ) dut (
        .clk(clk), .resetn(resetn), .fsync(fsync),
        .win_left(win_left), .win_top(win_top),
        .win_width(win_width), .win_height(win_height),
        .s_axis_tvalid(s_tvalid), .s_axis_tdata(s_tdata),
        .s_axis_tuser(s_tuser), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata),
        .m_axis_tuser(m_tuser), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // 0: always ready, 1: toggle 1010..., 2: held low
    always @(posedge clk) begin
        #1;
        case (rmode)
            0:       m_tready = 1'b1;
            1:       m_tready = ~m_tready;
            default: m_tready = 1'b0;
        endcase
    end

    // Monitor / scoreboard
    logic  pv = 1'b0, pr = 1'b0, pfs = 1'b0;
    beat_t pb = '0;
    always @(negedge clk) begin
        if (resetn) begin
            if (pv && !pr && !pfs)
                check("hold_stable", {21'd0, m_tvalid, m_tdata, m_tuser, m_tlast}, {21'd0, 1'b1, pb});
            if (s_tvalid && !s_tready) stall_cnt <= stall_cnt + 1;
            if (m_tvalid && m_tready) begin
                out_cnt <= out_cnt + 1;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", exp_q.size(), 1);
                end else begin
                    check("beat", {22'd0, m_tdata, m_tuser, m_tlast}, {22'd0, exp_q.pop_front()});
                    if (m_tuser) first_out_cyc <= cyc;
                end
            end
        end
        pv  <= m_tvalid && resetn;
        pr  <= m_tready;
        pfs <= fsync;
        pb  <= {m_tdata, m_tuser, m_tlast};
    end

    // All driver tasks start and end at posedge+1.
    task automatic send_beat(input logic [7:0] d, input logic u, input logic l);
        logic r, acc;
        acc      = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tuser  = u;
        s_tlast  = l;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk) r = s_tready;
            @(posedge clk);
            #1;
            if (r) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) check("accept_timeout", acc, 1);
        s_tvalid = 1'b0;
        s_tuser  = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_frame(input int cols, input int rows, input int mc, input int mr);
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++) begin
                send_beat({r[3:0], c[3:0]}, (r == 0 && c == 0), (c == cols - 1));
                if (c == mc && r == mr) mark_cyc = cyc;
            end
    endtask

    task automatic do_fsync(input int l, input int t, input int w, input int h);
        win_left   = l[WB-1:0];
        win_top    = t[HB-1:0];
        win_width  = w[WB-1:0];
        win_height = h[HB-1:0];
        fsync      = 1'b1;
        @(posedge clk);
        #1;
        fsync = 1'b0;
    endtask

    task automatic expect_beat(input logic [7:0] d, input logic u, input logic l);
        exp_q.push_back('{d: d, u: u, l: l});
    endtask

    task automatic drain(input string name);
        for (int t = 0; t < 300; t++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check(name, exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int st0, oc0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_m_tuser", m_tuser, 0);
        check("rst_m_tlast", m_tlast, 0);
        check("rst_s_tready", s_tready, 0);
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle_s_tready", s_tready, 0);

        // 1: basic window, full-rate output
        do_fsync(2, 1, 3, 2);
        expect_beat(8'h12, 1, 0); expect_beat(8'h13, 0, 0); expect_beat(8'h14, 0, 1);
        expect_beat(8'h22, 0, 0); expect_beat(8'h23, 0, 0); expect_beat(8'h24, 0, 1);
        send_frame(8, 4, 2, 1);
        drain("drain_basic");
        check("latency", first_out_cyc, mark_cyc);

        // 2: same window, toggling backpressure
        rmode = 1;
        st0 = stall_cnt;
        do_fsync(2, 1, 3, 2);
        expect_beat(8'h12, 1, 0); expect_beat(8'h13, 0, 0); expect_beat(8'h14, 0, 1);
        expect_beat(8'h22, 0, 0); expect_beat(8'h23, 0, 0); expect_beat(8'h24, 0, 1);
        send_frame(8, 4, -1, -1);
        drain("drain_toggle");
        check("tready_drop", (stall_cnt > st0), 1);
        rmode = 0;

        // 3: right-edge clip and window taller than the frame
        do_fsync(6, 0, 4, 10);
        expect_beat(8'h06, 1, 0); expect_beat(8'h07, 0, 1);
        expect_beat(8'h16, 0, 0); expect_beat(8'h17, 0, 1);
        expect_beat(8'h26, 0, 0); expect_beat(8'h27, 0, 1);
        expect_beat(8'h36, 0, 0); expect_beat(8'h37, 0, 1);
        send_frame(8, 4, -1, -1);
        drain("drain_clip");

        // 4: empty windows
        st0 = stall_cnt;
        oc0 = out_cnt;
        do_fsync(0, 0, 0, 4);
        send_frame(8, 4, -1, -1);
        do_fsync(0, 0, 8, 0);
        send_frame(8, 4, -1, -1);
        repeat (5) @(posedge clk);
        #1;
        check("empty_no_stall", stall_cnt, st0);
        check("empty_no_output", out_cnt, oc0);

        // 5: fsync flushes two buffered beats; garbage before tuser is dropped
        rmode = 2;
        @(posedge clk);
        #1;
        do_fsync(0, 0, 8, 4);
        send_beat(8'h00, 1, 0);
        send_beat(8'h01, 0, 0);
        check("full_s_tready", s_tready, 0);
        check("full_m_tvalid", m_tvalid, 1);
        do_fsync(1, 1, 2, 1);
        check("flush_m_tvalid", m_tvalid, 0);
        rmode = 0;
        expect_beat(8'h11, 1, 0); expect_beat(8'h12, 0, 1);
        send_beat(8'hA5, 0, 0);
        send_beat(8'hA6, 0, 1);
        send_beat(8'hA7, 0, 0);
        send_frame(8, 4, -1, -1);
        drain("drain_flush");

        // 6: asynchronous reset mid-frame, then IDLE until fsync
        rmode = 2;
        @(posedge clk);
        #1;
        do_fsync(0, 0, 8, 4);
        send_beat(8'h00, 1, 0);
        send_beat(8'h01, 0, 0);
        #2 resetn = 1'b0;
        #1;
        check("arst_m_tvalid", m_tvalid, 0);
        check("arst_m_tdata", m_tdata, 0);
        check("arst_s_tready", s_tready, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        resetn = 1'b1;
        rmode = 0;
        s_tvalid = 1'b1;
        s_tdata = 8'h55;
        s_tuser = 1'b1;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            check("post_rst_s_tready", s_tready, 0);
            check("post_rst_m_tvalid", m_tvalid, 0);
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tuser = 1'b0;
        do_fsync(0, 0, 2, 1);
        expect_beat(8'h00, 1, 0); expect_beat(8'h01, 0, 1);
        send_frame(4, 2, -1, -1);
        drain("drain_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
